// File: rtl/ycbcr_422_packer_pkg.sv
// Shared types for the 4:4:4 -> 4:2:2 YCbCr packer.
// Holds the pixel struct, output word type, FSM state encoding and default component width.
package ycbcr_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] y;
        logic [DATA_W_DEFAULT-1:0] cb;
        logic [DATA_W_DEFAULT-1:0] cr;
    } ycbcr_t;

    typedef logic [2*DATA_W_DEFAULT-1:0] packed_word_t;

    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } state_t;

endpackage

// File: rtl/ycbcr_422_packer_if.sv
// Pixel-in / packed-word-out stream bundle for ycbcr_422_packer.
// The slave modport is the packer's view; the master modport is the driving side.
interface ycbcr_422_packer_if #(
    parameter int unsigned DATA_W = ycbcr_pkg::DATA_W_DEFAULT
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_y;
    logic [DATA_W-1:0]   in_cb;
    logic [DATA_W-1:0]   in_cr;
    logic                in_sol;
    logic                in_eol;
    logic                out_valid;
    logic                out_ready;
    logic [2*DATA_W-1:0] out_data;
    logic                out_sol;
    logic                out_eol;

    modport master (
        output in_valid, in_y, in_cb, in_cr, in_sol, in_eol, out_ready,
        input  in_ready, out_valid, out_data, out_sol, out_eol
    );

    modport slave (
        input  in_valid, in_y, in_cb, in_cr, in_sol, in_eol, out_ready,
        output in_ready, out_valid, out_data, out_sol, out_eol
    );
endinterface

// File: rtl/ycbcr_422_packer_chroma_avg.sv
// Chroma reduction for one component pair: rounded average when CHROMA_AVG_EN is
// defined, otherwise co-sited decimation (first sample kept, second ignored).
module ycbcr_chroma_avg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] c0,
    input  logic [DATA_W-1:0] c1,
    output logic [DATA_W-1:0] c_out
);
`ifdef CHROMA_AVG_EN
    logic [DATA_W:0] sum;

    always_comb begin
        sum   = {1'b0, c0} + {1'b0, c1} + {{DATA_W{1'b0}}, 1'b1};
        c_out = sum[DATA_W:1];
    end
`else
    logic unused_c1;

    always_comb begin
        c_out     = c0;
        unused_c1 = ^c1;
    end
`endif
endmodule

// File: rtl/ycbcr_422_packer.sv
// Packs 4:4:4 YCbCr pixels into a 4:2:2 word stream {Y0,Cb'},{Y1,Cr'} with sol/eol
// carried through and odd lines padded. Chroma averaging selected by CHROMA_AVG_EN.
module ycbcr_422_packer
    import ycbcr_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    ycbcr_422_packer_if.slave     bus
);
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   p0_y_q, p0_y_d, p0_cb_q, p0_cb_d, p0_cr_q, p0_cr_d;
    logic                p0_sol_q, p0_sol_d;
    logic                out_valid_q, out_valid_d;
    logic [2*DATA_W-1:0] out_data_q, out_data_d;
    logic                out_sol_q, out_sol_d, out_eol_q, out_eol_d;
    logic                pend_valid_q, pend_valid_d;
    logic [2*DATA_W-1:0] pend_data_q, pend_data_d;
    logic                pend_eol_q, pend_eol_d;

    logic                in_ready, accept, pop, buf_room, from_in, a_sol;
    logic [DATA_W-1:0]   a_y, a_cb, a_cr, cb_out, cr_out;

    // P0 comes from the input itself for odd-line padding and for a sol restart mid-pair.
    always_comb begin
        buf_room = !out_valid_q || (bus.out_ready && !pend_valid_q);
        if (!rst)                                 in_ready = 1'b0;
        else if (state_q == S_EVEN && !bus.in_eol) in_ready = 1'b1;
        else                                      in_ready = buf_room;
        accept  = bus.in_valid && in_ready;
        pop     = out_valid_q && bus.out_ready;
        from_in = (state_q == S_EVEN) || bus.in_sol;
        a_y     = from_in ? bus.in_y   : p0_y_q;
        a_cb    = from_in ? bus.in_cb  : p0_cb_q;
        a_cr    = from_in ? bus.in_cr  : p0_cr_q;
        a_sol   = from_in ? bus.in_sol : p0_sol_q;
    end

    ycbcr_chroma_avg #(.DATA_W(DATA_W)) u_cb_avg (.c0(a_cb), .c1(bus.in_cb), .c_out(cb_out));
    ycbcr_chroma_avg #(.DATA_W(DATA_W)) u_cr_avg (.c0(a_cr), .c1(bus.in_cr), .c_out(cr_out));

    always_comb begin
        state_d      = state_q;
        p0_y_d       = p0_y_q;
        p0_cb_d      = p0_cb_q;
        p0_cr_d      = p0_cr_q;
        p0_sol_d     = p0_sol_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sol_d    = out_sol_q;
        out_eol_d    = out_eol_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        pend_eol_d   = pend_eol_q;

        if (pop) begin
            out_valid_d  = pend_valid_q;
            pend_valid_d = 1'b0;
            if (pend_valid_q) begin
                out_data_d = pend_data_q;
                out_sol_d  = 1'b0;
                out_eol_d  = pend_eol_q;
            end
        end

        // A pair load overrides the pop move; buf_room guarantees nothing is lost.
        if (accept) begin
            if (from_in && !bus.in_eol) begin
                p0_y_d   = bus.in_y;
                p0_cb_d  = bus.in_cb;
                p0_cr_d  = bus.in_cr;
                p0_sol_d = bus.in_sol;
                state_d  = S_ODD;
            end else begin
                out_valid_d  = 1'b1;
                out_data_d   = {a_y, cb_out};
                out_sol_d    = a_sol;
                out_eol_d    = 1'b0;
                pend_valid_d = 1'b1;
                pend_data_d  = {bus.in_y, cr_out};
                pend_eol_d   = bus.in_eol;
                state_d      = S_EVEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_EVEN;
            p0_y_q       <= '0;
            p0_cb_q      <= '0;
            p0_cr_q      <= '0;
            p0_sol_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sol_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            pend_eol_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            p0_y_q       <= p0_y_d;
            p0_cb_q      <= p0_cb_d;
            p0_cr_q      <= p0_cr_d;
            p0_sol_q     <= p0_sol_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sol_q    <= out_sol_d;
            out_eol_q    <= out_eol_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            pend_eol_q   <= pend_eol_d;
        end
    end

    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
        bus.out_sol   = out_sol_q;
        bus.out_eol   = out_eol_q;
    end
endmodule

// File: tb/tb_ycbcr_422_packer.sv
// Directed bench for ycbcr_422_packer; expectations follow CHROMA_AVG_EN when defined.
`timescale 1ns/1ps
module tb_ycbcr_422_packer;
    import ycbcr_pkg::*;

    localparam int unsigned W = DATA_W_DEFAULT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ycbcr_422_packer_if #(.DATA_W(W)) bus ();
    ycbcr_422_packer #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] d;
        logic        s;
        logic        e;
        int          c;
    } word_t;

    typedef struct {
        ycbcr_t      px0;
        ycbcr_t      px1;
        bit          two;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    blocked = 0;
    word_t got[$];
    logic        stall_prev = 1'b0;
    logic [17:0] stall_word = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.in_valid && !bus.in_ready) blocked <= blocked + 1;
            if (bus.out_valid && bus.out_ready)
                got.push_back('{bus.out_data, bus.out_sol, bus.out_eol, cyc});
            if (bus.out_valid && !bus.out_ready) begin
                if (stall_prev)
                    check("hold_stable", 32'({bus.out_sol, bus.out_eol, bus.out_data}), 32'(stall_word));
                stall_prev <= 1'b1;
                stall_word <= {bus.out_sol, bus.out_eol, bus.out_data};
            end else begin
                stall_prev <= 1'b0;
            end
        end else begin
            stall_prev <= 1'b0;
        end
    end

    function automatic logic [7:0] cexp(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
`ifdef CHROMA_AVG_EN
        return s[8:1];
`else
        return (s == s) ? a : b;
`endif
    endfunction

    task automatic send_pixel(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                              input logic sol, input logic eol);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_y     = y;
        bus.in_cb    = cb;
        bus.in_cr    = cr;
        bus.in_sol   = sol;
        bus.in_eol   = eol;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_words(input int n, input string nm);
        for (int i = 0; i < 100 && got.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check({nm, "_count"}, 32'(got.size()), 32'(n));
    endtask

    task automatic check_word(input string nm, input int idx, input logic [15:0] d,
                              input logic s, input logic e);
        if (idx < got.size()) begin
            check({nm, "_data"}, 32'(got[idx].d), 32'(d));
            check({nm, "_sol"},  32'(got[idx].s), 32'(s));
            check({nm, "_eol"},  32'(got[idx].e), 32'(e));
        end else begin
            check({nm, "_present"}, 32'(got.size()), 32'(idx + 1));
        end
    endtask

    function automatic ycbcr_t line_px(input int i);
        ycbcr_t p;
        p.y  = 8'(8'h10 + i);
        p.cb = 8'(8'h40 + 3 * i);
        p.cr = 8'(8'hA0 + 5 * i);
        return p;
    endfunction

    task automatic check_line(input string nm);
        for (int k = 0; k < 4; k++) begin
            ycbcr_t a, b;
            a = line_px(2 * k);
            b = line_px(2 * k + 1);
            check_word(nm, 2 * k,     {a.y, cexp(a.cb, b.cb)}, k == 0, 1'b0);
            check_word(nm, 2 * k + 1, {b.y, cexp(a.cr, b.cr)}, 1'b0, k == 3);
        end
    endtask

    vec_t vecs[6];

    initial begin
        int acc_cyc;
        int b0;
        ycbcr_t p;

`ifdef CHROMA_AVG_EN
        vecs[0] = '{'{8'd50, 8'd100, 8'd200}, '{8'd60, 8'd103, 8'd210}, 1'b1, 16'h3266, 16'h3CCD};
        vecs[2] = '{'{8'd0, 8'd0, 8'd0}, '{8'd255, 8'd255, 8'd255}, 1'b1, 16'h0080, 16'hFF80};
        vecs[5] = '{'{8'd1, 8'd1, 8'd2}, '{8'd2, 8'd2, 8'd3}, 1'b1, 16'h0102, 16'h0203};
`else
        vecs[0] = '{'{8'd50, 8'd100, 8'd200}, '{8'd60, 8'd103, 8'd210}, 1'b1, 16'h3264, 16'h3CC8};
        vecs[2] = '{'{8'd0, 8'd0, 8'd0}, '{8'd255, 8'd255, 8'd255}, 1'b1, 16'h0000, 16'hFF00};
        vecs[5] = '{'{8'd1, 8'd1, 8'd2}, '{8'd2, 8'd2, 8'd3}, 1'b1, 16'h0101, 16'h0202};
`endif
        vecs[1] = '{'{8'd50, 8'd100, 8'd200}, '{8'd0, 8'd0, 8'd0}, 1'b0, 16'h3264, 16'h32C8};
        vecs[3] = '{'{8'd255, 8'd255, 8'd255}, '{8'd255, 8'd255, 8'd255}, 1'b1, 16'hFFFF, 16'hFFFF};
        vecs[4] = '{'{8'h12, 8'h34, 8'h56}, '{8'd0, 8'd0, 8'd0}, 1'b0, 16'h1234, 16'h1256};

        bus.in_valid  = 1'b1;
        bus.in_y      = 8'd7;
        bus.in_cb     = 8'd7;
        bus.in_cr     = 8'd7;
        bus.in_sol    = 1'b1;
        bus.in_eol    = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            got.delete();
            if (vecs[v].two) begin
                send_pixel(vecs[v].px0.y, vecs[v].px0.cb, vecs[v].px0.cr, 1'b1, 1'b0);
                send_pixel(vecs[v].px1.y, vecs[v].px1.cb, vecs[v].px1.cr, 1'b0, 1'b1);
            end else begin
                send_pixel(vecs[v].px0.y, vecs[v].px0.cb, vecs[v].px0.cr, 1'b1, 1'b1);
            end
            bus.in_valid = 1'b0;
            wait_words(2, $sformatf("vec%0d", v));
            check_word($sformatf("vec%0d_w0", v), 0, vecs[v].w0, 1'b1, 1'b0);
            check_word($sformatf("vec%0d_w1", v), 1, vecs[v].w1, 1'b0, 1'b1);
        end

        // Full-rate line: one pixel per cycle with no waiting on in_ready.
        got.delete();
        b0 = blocked;
        acc_cyc = -100;
        for (int i = 0; i < 8; i++) begin
            p = line_px(i);
            bus.in_valid = 1'b1;
            bus.in_y     = p.y;
            bus.in_cb    = p.cb;
            bus.in_cr    = p.cr;
            bus.in_sol   = (i == 0);
            bus.in_eol   = (i == 7);
            @(negedge clk);
            if (i == 0 && bus.in_ready) acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        wait_words(8, "tput");
        check("tput_in_ready_drops", 32'(blocked - b0), 32'd0);
        if (got.size() > 0)
            check("tput_first_latency", 32'(got[0].c - acc_cyc), 32'd2);
        for (int k = 1; k < 8 && k < got.size(); k++)
            check($sformatf("tput_gap%0d", k), 32'(got[k].c - got[k-1].c), 32'd1);
        check_line("tput");

        // Same line with a 5-cycle output stall in the middle.
        got.delete();
        b0 = blocked;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    p = line_px(i);
                    send_pixel(p.y, p.cb, p.cr, i == 0, i == 7);
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_words(8, "bp");
        check("bp_in_ready_dropped", 32'((blocked - b0) > 0), 32'd1);
        check_line("bp");

        // A restart sol mid-pair discards the held pixel.
        got.delete();
        send_pixel(8'd10, 8'd20, 8'd30, 1'b1, 1'b0);
        send_pixel(8'd40, 8'd50, 8'd60, 1'b1, 1'b0);
        send_pixel(8'd70, 8'd80, 8'd90, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        wait_words(2, "midsol");
`ifdef CHROMA_AVG_EN
        check_word("midsol_w0", 0, 16'h2841, 1'b1, 1'b0);
        check_word("midsol_w1", 1, 16'h464B, 1'b0, 1'b1);
`else
        check_word("midsol_w0", 0, 16'h2832, 1'b1, 1'b0);
        check_word("midsol_w1", 1, 16'h463C, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end
endmodule
